ts_tx_pacer: RTL

Per-lane training-sequence transmitter. It assembles a 128-bit TS1 or TS2 ordered set from link-training fields and emits it on a one-cycle valid strobe at the cadence of the negotiated generation. It feeds one lane's `laneN_ts_i`/`laneN_ts_i_vld` input of the LTSSM on the far side of the link. The LTSSM drives it to send fixed-length bursts (e.g. 1024 TS1, 16 TS2) or a continuous stream.

---
 rtl/ts_tx_pacer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ts_tx_pacer.sv
// ts_tx_pacer
// -----------
// Per-lane training-sequence transmitter. On an accepted start it captures
// the link-training fields, assembles a 128-bit TS1/TS2 ordered set, and
// emits it on a one-cycle valid strobe every I cycles. I is 64/32/16/8/4
// cycles for gen1..gen5. Bursts are either fixed length (burst_len != 0)
// or a continuous stream (burst_len == 0) that runs until stop.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a burst (sampled only in IDLE)
//   stop       in   abort an active burst/stream (sampled only in ACTIVE)
//   burst_len  in   [10:0] number of TS to send, 0 = continuous
//   gen        in   [2:0]  generation 1..5, other values behave as gen1
//   ts_type    in   0 = TS1, 1 = TS2
//   link_num   in   [7:0] symbol 1 unless link_pad
//   link_pad   in   symbol 1 = PAD (0xF7)
//   lane_num   in   [7:0] symbol 2 unless lane_pad
//   lane_pad   in   symbol 2 = PAD (0xF7)
//   n_fts      in   [7:0] symbol 3
//   rate_id    in   [7:0] symbol 4
//   train_ctrl in   [7:0] symbol 5
//   ts_o       out  [127:0] assembled TS, symbol i at bits [8i+7:8i]
//   ts_o_vld   out  one-cycle strobe, ts_o valid in that cycle
//   busy       out  high while ACTIVE
//   done       out  one-cycle pulse on normal burst completion
//   sent_cnt   out  [10:0] TS emitted since the last start (saturates)
//
// Handshake: there is no back-pressure. A TS is transferred exactly in the
// cycles where ts_o_vld is high; the consumer must take it then. start and
// stop are level-sampled commands, honoured only in IDLE and ACTIVE
// respectively.

module ts_tx_pacer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [10:0]  burst_len,
  input  logic [2:0]   gen,
  input  logic         ts_type,
  input  logic [7:0]   link_num,
  input  logic         link_pad,
  input  logic [7:0]   lane_num,
  input  logic         lane_pad,
  input  logic [7:0]   n_fts,
  input  logic [7:0]   rate_id,
  input  logic [7:0]   train_ctrl,
  output logic [127:0] ts_o,
  output logic         ts_o_vld,
  output logic         busy,
  output logic         done,
  output logic [10:0]  sent_cnt
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [7:0]  SYM_COM = 8'hBC;
  localparam logic [7:0]  SYM_PAD = 8'hF7;
  localparam logic [7:0]  ID_TS1  = 8'h4A;
  localparam logic [7:0]  ID_TS2  = 8'h45;
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  state_t         state_q, state_d;
  logic [5:0]     timer_q, timer_d;
  logic [5:0]     ivl_q,   ivl_d;     // captured interval minus one
  logic [10:0]    blen_q,  blen_d;
  logic [10:0]    cnt_q,   cnt_d;
  logic [127:0]   ts_q,    ts_d;
  logic           vld_q,   vld_d;
  logic           done_q,  done_d;

  logic [127:0]   ts_asm;
  logic [5:0]     ivl_in;

  // Assemble the ordered set from the live field inputs; it is only
  // latched into ts_q on an accepted start, so later input changes are
  // invisible for the rest of the burst.
  always_comb begin
    ts_asm          = '0;
    ts_asm[7:0]     = SYM_COM;
    ts_asm[15:8]    = link_pad ? SYM_PAD : link_num;
    ts_asm[23:16]   = lane_pad ? SYM_PAD : lane_num;
    ts_asm[31:24]   = n_fts;
    ts_asm[39:32]   = rate_id;
    ts_asm[47:40]   = train_ctrl;
    for (int i = 6; i < 16; i++) begin
      ts_asm[8*i +: 8] = ts_type ? ID_TS2 : ID_TS1;
    end
  end

  // Timer reload value (I-1); unsupported generations fall back to gen1.
  always_comb begin
    case (gen)
      3'd2:    ivl_in = 6'd31;
      3'd3:    ivl_in = 6'd15;
      3'd4:    ivl_in = 6'd7;
      3'd5:    ivl_in = 6'd3;
      default: ivl_in = 6'd63;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ivl_d   = ivl_q;
    blen_d  = blen_q;
    cnt_d   = cnt_q;
    ts_d    = ts_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // stop has no meaning here, so start+stop together starts a burst.
        if (start) begin
          state_d = S_ACTIVE;
          vld_d   = 1'b1;
          ts_d    = ts_asm;
          cnt_d   = 11'd1;
          timer_d = ivl_in;
          ivl_d   = ivl_in;
          blen_d  = burst_len;
        end
      end

      S_ACTIVE: begin
        if (stop) begin
          // Abort wins even over a strobe that was due this edge.
          state_d = S_IDLE;
        end else if (timer_q == 6'd0) begin
          if ((blen_q != 11'd0) && (cnt_q == blen_q)) begin
            // The last TS has had its full I-cycle slot; finish now.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            vld_d   = 1'b1;
            timer_d = ivl_q;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 11'd1;
            end
          end
        end else begin
          timer_d = timer_q - 6'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      ivl_q   <= '0;
      blen_q  <= '0;
      cnt_q   <= '0;
      ts_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ivl_q   <= ivl_d;
      blen_q  <= blen_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign ts_o     = ts_q;
  assign ts_o_vld = vld_q;
  assign busy     = (state_q == S_ACTIVE);
  assign done     = done_q;
  assign sent_cnt = cnt_q;

endmodule
